// File: rtl/mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mem_seq
//  Description : Memory access sequencer between the core's byte bus and an
//                external asynchronous 8-bit SRAM/ROM.
//
//                Each core access becomes one timed SRAM cycle:
//                  SETUP (1 clk) -> ACCESS (WAIT clks) -> READY (1 clk).
//                The core is stalled by holding `locked` low. `locked` is high
//                for exactly one clock per access (READY).
//
//                A one-entry read buffer (tag + valid) lets a repeated read of
//                the same address go SETUP -> READY directly. The SRAM is
//                never enabled for such a hit.
//
//  Parameters  : WAIT        SRAM access clocks per access (1..15)
//                HIT_EN      1 = enable the one-entry read-hit buffer
//                RESET_HOLD  idle clocks after reset before the first access
//                            (1..15)
//
//  Ports       : clock        in   system clock
//                reset        in   synchronous reset, active-high
//                pll_locked   in   clock source stable; gates access start
//                cpu_address  in   20-bit core byte address (stable while
//                                  locked=0)
//                cpu_out      in   core write data
//                cpu_we       in   core write strobe
//                cpu_in       out  registered read data to the core
//                locked       out  core enable, one clock per access
//                sram_a       out  registered SRAM address
//                sram_d_i     in   SRAM data in
//                sram_d_o     out  SRAM data out
//                sram_d_oe    out  SRAM data-pin driver enable
//                sram_ce_n    out  chip enable, active-low
//                sram_oe_n    out  output enable, active-low
//                sram_we_n    out  write enable, active-low
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_seq #(
    parameter int WAIT       = 2,
    parameter int HIT_EN     = 1,
    parameter int RESET_HOLD = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pll_locked,
    input  logic [19:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_we,
    output logic [7:0]  cpu_in,
    output logic        locked,
    output logic [19:0] sram_a,
    input  logic [7:0]  sram_d_i,
    output logic [7:0]  sram_d_o,
    output logic        sram_d_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    // ------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_st_holdoff = 2'd0;
    localparam logic [1:0] c_st_setup   = 2'd1;
    localparam logic [1:0] c_st_access  = 2'd2;
    localparam logic [1:0] c_st_ready   = 2'd3;

    // The ACCESS counter runs WAIT-1 down to 0, giving WAIT clocks in ACCESS.
    localparam logic [3:0] c_wait_init = 4'(WAIT - 1);
    localparam logic [3:0] c_hold_init = 4'(RESET_HOLD);
    // Re-entry into HOLDOFF after pll_locked drops waits one extra clock.
    localparam logic [3:0] c_relock_init = 4'd1;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [3:0]  r_cnt;
    logic [19:0] r_tag;
    logic        r_valid;
    logic        r_is_write;   // direction of the access in flight
    logic        w_cnt_zero;
    logic        w_hit;

    assign w_cnt_zero = (r_cnt == 4'd0);

    // ------------------------------------------------------------------
    // Read-hit detection. Only a read can hit; the full 20-bit address is
    // compared against the buffered tag.
    // ------------------------------------------------------------------
    generate
        if (HIT_EN != 0) begin : g_hit_buf
            assign w_hit = !cpu_we && r_valid && (cpu_address == r_tag);
        end else begin : g_no_hit_buf
            assign w_hit = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_holdoff;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // pll_locked is looked at only in HOLDOFF and READY, so an access that
    // has started always runs to completion.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_holdoff: begin
                if (w_cnt_zero && pll_locked) begin
                    w_next_state = c_st_setup;
                end
            end
            c_st_setup: begin
                w_next_state = w_hit ? c_st_ready : c_st_access;
            end
            c_st_access: begin
                if (w_cnt_zero) begin
                    w_next_state = c_st_ready;
                end
            end
            c_st_ready: begin
                w_next_state = pll_locked ? c_st_setup : c_st_holdoff;
            end
            default: begin
                w_next_state = c_st_holdoff;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        locked = (r_state == c_st_ready);
    end

    // ------------------------------------------------------------------
    // Datapath and SRAM strobes
    //
    // Write timing, as seen on the pins:
    //   SETUP exit : address, data, ce_n=0, d_oe=1, we_n=0
    //   ACCESS     : we_n low for all WAIT clocks
    //   last ACCESS exit : we_n=1
    //   READY exit : ce_n=1, d_oe=0
    // so the data driver outlasts we_n by one clock (hold time).
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= c_hold_init;
            cpu_in     <= 8'h00;
            sram_a     <= 20'h00000;
            sram_d_o   <= 8'h00;
            sram_d_oe  <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            r_tag      <= 20'h00000;
            r_valid    <= 1'b0;
            r_is_write <= 1'b0;
        end else begin
            case (r_state)
                c_st_holdoff: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                c_st_setup: begin
                    sram_a     <= cpu_address;
                    sram_d_o   <= cpu_out;
                    r_is_write <= cpu_we;
                    // A hit is served from cpu_in as it stands; the SRAM is
                    // left disabled.
                    if (!w_hit) begin
                        sram_ce_n <= 1'b0;
                        r_cnt     <= c_wait_init;
                        if (cpu_we) begin
                            sram_d_oe <= 1'b1;
                            sram_we_n <= 1'b0;
                        end else begin
                            sram_oe_n <= 1'b0;
                        end
                    end
                end

                c_st_access: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (r_is_write) begin
                        // Any write drops the buffer, whatever its address.
                        r_valid   <= 1'b0;
                        sram_we_n <= 1'b1;
                    end else begin
                        cpu_in  <= sram_d_i;
                        r_tag   <= sram_a;
                        r_valid <= 1'b1;
                    end
                end

                c_st_ready: begin
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_d_oe <= 1'b0;
                    sram_we_n <= 1'b1;
                    if (!pll_locked) begin
                        r_cnt <= c_relock_init;
                    end
                end

                default: begin
                    r_cnt <= c_hold_init;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_seq
//  Description : Self-checking bench for mem_seq. An SRAM model answers the
//                sequencer; a reference model (memory contents, buffered
//                address, last read value) predicts read data, latency and
//                strobe durations for every core access.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_seq;

    localparam int WAIT       = 2;
    localparam int HIT_EN     = 1;
    localparam int RESET_HOLD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pll_locked = 1'b0;
    logic [19:0] cpu_address = 20'h0;
    logic [7:0]  cpu_out = 8'h0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_in;
    logic        locked;
    logic [19:0] sram_a;
    logic [7:0]  sram_d_i;
    logic [7:0]  sram_d_o;
    logic        sram_d_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int checks = 0;
    int errors = 0;

    mem_seq #(
        .WAIT       (WAIT),
        .HIT_EN     (HIT_EN),
        .RESET_HOLD (RESET_HOLD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .cpu_in      (cpu_in),
        .locked      (locked),
        .sram_a      (sram_a),
        .sram_d_i    (sram_d_i),
        .sram_d_o    (sram_d_o),
        .sram_d_oe   (sram_d_oe),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // SRAM model: 256 bytes aliased on addr[7:0]. Unwritten bytes read as
    // addr[7:0]^1A (so FFFF0 reads EA).
    // ------------------------------------------------------------------
    bit [7:0] mem [256];
    bit       wr  [256];

    always @(posedge clock) begin
        if (!sram_ce_n && !sram_we_n && sram_d_oe) begin
            mem[sram_a[7:0]] <= sram_d_o;
            wr[sram_a[7:0]]  <= 1'b1;
        end
    end

    always_comb begin
        sram_d_i = 8'h00;
        if (!sram_ce_n && !sram_oe_n) begin
            sram_d_i = wr[sram_a[7:0]] ? mem[sram_a[7:0]] : (sram_a[7:0] ^ 8'h1A);
        end
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit [7:0]  ref_mem [256];
    bit        ref_wr  [256];
    bit        ref_valid = 1'b0;
    bit [19:0] ref_tag = 20'h0;
    bit [7:0]  ref_cpu_in = 8'h00;

    function automatic logic [7:0] ref_read(input logic [19:0] a);
        return ref_wr[a[7:0]] ? ref_mem[a[7:0]] : (a[7:0] ^ 8'h1A);
    endfunction

    // One core access: drive it, follow it to its locked pulse, compare
    // what was seen with the model, then update the model.
    task automatic run_access(input bit we, input logic [19:0] addr, input logic [7:0] data,
                              input int extra, input bit chk_lat, input int drop_at,
                              input string name);
        bit         hit;
        int         exp_lat;
        int         n;
        int         we_lo;
        int         ce_lo;
        int         oe_lo;
        int         doe_hi;
        int         first_ce;
        bit         got;
        logic [7:0] exp_in;
        hit     = (HIT_EN != 0) && !we && ref_valid && (ref_tag == addr);
        exp_lat = extra + (hit ? 2 : WAIT + 2);
        exp_in  = we ? ref_cpu_in : ref_read(addr);
        cpu_we = we; cpu_address = addr; cpu_out = data;
        n = 0; we_lo = 0; ce_lo = 0; oe_lo = 0; doe_hi = 0; first_ce = 0; got = 1'b0;
        while (n < 200 && !got) begin
            @(negedge clock);
            n++;
            if (n == drop_at) pll_locked = 1'b0;
            if (!sram_we_n) we_lo++;
            if (!sram_ce_n) begin
                ce_lo++;
                if (first_ce == 0) first_ce = n;
            end
            if (!sram_oe_n) oe_lo++;
            if (sram_d_oe) doe_hi++;
            if (locked) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no locked pulse within %0d clocks", name, n);
            return;
        end
        if (chk_lat) begin
            checks++;
            if (n !== exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
            end
        end
        checks++;
        if (cpu_in !== exp_in) begin
            errors++;
            $display("FAIL %s cpu_in: got %02h expected %02h", name, cpu_in, exp_in);
        end
        checks++;
        if (sram_a !== addr) begin
            errors++;
            $display("FAIL %s sram_a: got %05h expected %05h", name, sram_a, addr);
        end
        checks++;
        if (we_lo !== (we ? WAIT : 0)) begin
            errors++;
            $display("FAIL %s we_n low clocks: got %0d expected %0d", name, we_lo, we ? WAIT : 0);
        end
        checks++;
        if (ce_lo !== (hit ? 0 : WAIT + 1)) begin
            errors++;
            $display("FAIL %s ce_n low clocks: got %0d expected %0d", name, ce_lo, hit ? 0 : WAIT + 1);
        end
        checks++;
        if (oe_lo !== ((!we && !hit) ? WAIT + 1 : 0)) begin
            errors++;
            $display("FAIL %s oe_n low clocks: got %0d expected %0d", name, oe_lo,
                     (!we && !hit) ? WAIT + 1 : 0);
        end
        checks++;
        if (doe_hi !== (we ? WAIT + 1 : 0)) begin
            errors++;
            $display("FAIL %s d_oe high clocks: got %0d expected %0d", name, doe_hi, we ? WAIT + 1 : 0);
        end
        if (!hit) begin
            checks++;
            if (first_ce !== extra + 2) begin
                errors++;
                $display("FAIL %s first ce_n low clock: got %0d expected %0d", name, first_ce, extra + 2);
            end
        end
        if (we) begin
            checks++;
            if (sram_d_o !== data || sram_we_n !== 1'b1 || sram_d_oe !== 1'b1) begin
                errors++;
                $display("FAIL %s write tail: d_o=%02h we_n=%b d_oe=%b expected d_o=%02h we_n=1 d_oe=1",
                         name, sram_d_o, sram_we_n, sram_d_oe, data);
            end
            ref_mem[addr[7:0]] = data;
            ref_wr[addr[7:0]]  = 1'b1;
            ref_valid = 1'b0;
        end else begin
            ref_valid  = 1'b1;
            ref_tag    = addr;
            ref_cpu_in = exp_in;
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        pll_locked = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (locked !== 1'b0 || cpu_in !== 8'h00 || sram_ce_n !== 1'b1 || sram_oe_n !== 1'b1 ||
            sram_we_n !== 1'b1 || sram_d_oe !== 1'b0 || sram_a !== 20'h0 || sram_d_o !== 8'h00) begin
            errors++;
            $display("FAIL reset values: locked=%b cpu_in=%02h ce_n=%b oe_n=%b we_n=%b d_oe=%b a=%05h d_o=%02h expected 0 00 1 1 1 0 00000 00",
                     locked, cpu_in, sram_ce_n, sram_oe_n, sram_we_n, sram_d_oe, sram_a, sram_d_o);
        end
        reset = 1'b0;
        ref_valid = 1'b0;
        ref_cpu_in = 8'h00;
        run_access(1'b0, 20'h12345, 8'h00, RESET_HOLD, 1'b1, 0, "first_after_reset");
    endtask

    task automatic test_read_miss();
        run_access(1'b0, 20'hFFFF0, 8'h00, 0, 1'b1, 0, "read_FFFF0");
        checks++;
        if (cpu_in !== 8'hEA) begin
            errors++;
            $display("FAIL read_FFFF0 value: got %02h expected EA", cpu_in);
        end
    endtask

    task automatic test_write();
        run_access(1'b1, 20'h00167, 8'h5A, 0, 1'b1, 0, "write_00167");
        run_access(1'b0, 20'h00167, 8'h00, 0, 1'b1, 0, "readback_00167");
    endtask

    task automatic test_read_hit();
        run_access(1'b0, 20'h00100, 8'h00, 0, 1'b1, 0, "read_00100_first");
        run_access(1'b0, 20'h00100, 8'h00, 0, 1'b1, 0, "read_00100_hit");
        run_access(1'b0, 20'h10100, 8'h00, 0, 1'b1, 0, "read_10100_tag_miss");
        run_access(1'b1, 20'h00200, 8'($urandom), 0, 1'b1, 0, "write_other");
        run_access(1'b0, 20'h10100, 8'h00, 0, 1'b1, 0, "read_after_write");
    endtask

    task automatic test_reset_abort();
        logic [7:0] d;
        d = 8'($urandom);
        run_access(1'b0, 20'h00055, 8'h00, 0, 1'b1, 0, "abort_prime_buffer");
        cpu_we = 1'b1; cpu_address = 20'h00321; cpu_out = d;
        @(negedge clock);                 // SETUP
        @(negedge clock);                 // first ACCESS clock
        checks++;
        if (sram_we_n !== 1'b0) begin
            errors++;
            $display("FAIL abort we_n during access: got %b expected 0", sram_we_n);
        end
        reset = 1'b1;
        @(negedge clock);
        // The SRAM saw we_n low at the reset edge, so the byte landed.
        ref_mem[8'h21] = d;
        ref_wr[8'h21]  = 1'b1;
        ref_valid  = 1'b0;
        ref_cpu_in = 8'h00;
        checks++;
        if (sram_we_n !== 1'b1 || locked !== 1'b0 || sram_ce_n !== 1'b1 || sram_d_oe !== 1'b0 ||
            cpu_in !== 8'h00) begin
            errors++;
            $display("FAIL abort state: we_n=%b locked=%b ce_n=%b d_oe=%b cpu_in=%02h expected 1 0 1 0 00",
                     sram_we_n, locked, sram_ce_n, sram_d_oe, cpu_in);
        end
        reset = 1'b0;
        run_access(1'b0, 20'h00055, 8'h00, RESET_HOLD, 1'b1, 0, "abort_buffer_invalid");
        run_access(1'b0, 20'h00321, 8'h00, 0, 1'b1, 0, "abort_written_byte");
    endtask

    task automatic test_pll_drop();
        bit bad;
        run_access(1'b0, 20'h0ABCD, 8'h00, 0, 1'b1, 2, "pll_drop_read");
        cpu_we = 1'b0; cpu_address = 20'h54321;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (locked !== 1'b0 || sram_ce_n !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL pll_idle: access activity while pll_locked=0 (locked=%b ce_n=%b) expected none",
                     locked, sram_ce_n);
        end
        pll_locked = 1'b1;
        run_access(1'b0, 20'h54321, 8'h00, 0, 1'b1, 0, "pll_relock_read");
    endtask

    task automatic test_random();
        logic [19:0] pool [8];
        logic [19:0] prev;
        logic [19:0] a;
        bit          we;
        pool[0] = 20'h00100; pool[1] = 20'h10100; pool[2] = 20'hFFFF0; pool[3] = 20'h00167;
        pool[4] = 20'h54321; pool[5] = 20'h0ABCD; pool[6] = 20'h7FF80; pool[7] = 20'h00001;
        prev = 20'h54321;
        for (int i = 0; i < 40; i++) begin
            we = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 9) < 4) ? prev : pool[$urandom_range(0, 7)];
            run_access(we, a, 8'($urandom), 0, 1'b1, 0, "random");
            prev = a;
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write();
        test_read_hit();
        test_reset_abort();
        test_pll_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
